pw_shift_tx: RTL



---
 rtl/pw_pkg.sv | 33 +++
 rtl/sync2.sv | 24 ++
 rtl/pw_shift_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// Shared types and constants for the serial password transmitter.
// This covers the FSM state type, the default timing and the reference password.
package pw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_HOLD,
    ST_CHECK,
    ST_DONE
  } tx_state_t;

  localparam int PW_WIDTH  = 64;
  localparam int DEF_SETUP = 4;
  localparam int DEF_HIGH  = 4;
  localparam int DEF_HOLD  = 4;
  localparam int DEF_CHECK = 8;

  localparam logic [63:0] PW_GOOD = 64'h39C3_ADF0_E798_E1BC;

  function automatic int max5(input int a, input int b, input int c,
                              input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// The reset clears both stages to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pw_shift_tx.sv
// Shifts a password MSB-first into a shift-register lock.
// The shift strobe has programmable setup/high/hold timing; after the last bit the lock's correct flag is sampled.
module pw_shift_tx
  import pw_pkg::*;
#(
  parameter int WIDTH        = PW_WIDTH,
  parameter int SETUP_CYCLES = DEF_SETUP,
  parameter int HIGH_CYCLES  = DEF_HIGH,
  parameter int HOLD_CYCLES  = DEF_HOLD,
  parameter int CHECK_CYCLES = DEF_CHECK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  input  logic             correct,
  output logic             shift,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             match
);

  localparam int CW = $clog2(max5(WIDTH, SETUP_CYCLES, HIGH_CYCLES,
                                  HOLD_CYCLES, CHECK_CYCLES) + 1);

  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] L_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHECK_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = CW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shl;
  logic             shift_q, shift_d;
  logic             d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic             corr_sync;

  sync2 u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (correct),
    .q_o   (corr_sync)
  );

  assign sr_shl = sr_q << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    shift_d = shift_q;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = word;
          bit_d   = B_LAST;
          d_d     = word[WIDTH-1];
          busy_d  = 1'b1;
          match_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == S_LAST) begin
          cnt_d   = '0;
          shift_d = 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_q == H_LAST) begin
          cnt_d   = '0;
          shift_d = 1'b0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == L_LAST) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            d_d     = 1'b0;
            state_d = ST_CHECK;
          end else begin
            // next bit goes out on the same edge that restarts setup
            bit_d   = bit_q - CW'(1);
            sr_d    = sr_shl;
            d_d     = sr_shl[WIDTH-1];
            state_d = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CHECK: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          match_d = corr_sync;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      shift_q <= 1'b0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      shift_q <= shift_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign shift = shift_q;
  assign d     = d_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign match = match_q;

endmodule
